uart_tx_buffered: RTL and testbench
===================================

# uart_tx_buffered

Buffered UART transmitter that consumes the byte stream produced by the station and navigation FSMs (`tx_data` / `tx_valid` / `tx_ready`) and serialises it onto the robot's wireless-link TX pin. A small FIFO decouples the FSMs from the slow serial line, so a one-cycle `tx_valid` pulse is never lost while a previous frame is still on the wire. Frame format is 8N1, with an optional compile-time parity bit.

## Interface
Parameters:
- `CLK_FREQ`, default 100_000_000: clock frequency in Hz.
- `BAUD`, default 115200: line rate. `CLKS_PER_BIT = CLK_FREQ / BAUD` uses integer division (868 at the defaults).
- `DEPTH`, default 4: number of FIFO entries. Must be a power of two, 2 or greater.
- `PARITY_ODD`, default 0: parity sense, used only when parity is compiled in. 0 selects even parity, 1 selects odd parity.

Ports:
- `clk` in 1: system clock. The block uses one clock.
- `reset` in 1: synchronous, active-high reset.
- `tx_data` in 8: byte to send. Sampled only on a write.
- `tx_valid` in 1: write request.
- `tx_ready` out 1: FIFO can accept a byte. Defined as `!full && !reset`.
- `tx` out 1: serial line. Registered; idles high.
- `tx_busy` out 1: high when the serializer is not IDLE or the FIFO is non-empty.

## Operation
Write side:
- A write occurs on any rising edge where `tx_valid && tx_ready`. The byte goes into the FIFO tail and the count increments.
- `tx_valid` while `tx_ready` is low is ignored. The byte is dropped and no error is raised. Upstream must hold `tx_valid` until it sees `tx_ready`.
- An upstream that holds `tx_valid` high continuously enqueues one byte per cycle until the FIFO is full. This is intended behaviour.

Serializer state machine (IDLE, START, DATA, PARITY, STOP):
- **IDLE:** `tx` = 1. If the FIFO is non-empty at an edge, pop the head into the shift register, load the baud counter, and go to START.
- **START:** `tx` = 0 for `CLKS_PER_BIT` cycles, then go to DATA with bit index 0.
- **DATA:** `tx` = shift[0] (LSB first) for `CLKS_PER_BIT` cycles per bit, then shift right. After bit 7, go to PARITY if it is compiled in, otherwise to STOP.
- **PARITY:** `tx` = ^byte, XORed with `PARITY_ODD`, for `CLKS_PER_BIT` cycles.
- **STOP:** `tx` = 1 for `CLKS_PER_BIT` cycles.
  - On the last stop cycle, if the FIFO is non-empty, pop and go straight to START, leaving no idle gap.
  - Otherwise, go to IDLE.

Counters and FIFO:
- The baud counter is `$clog2(CLKS_PER_BIT)` bits wide and counts down from `CLKS_PER_BIT-1` to 0.
- The bit index is 3 bits.
- The FIFO count is `$clog2(DEPTH)+1` bits.
- The read and write pointers wrap modulo `DEPTH`.

Boundary conditions:
- **Write and pop on the same edge, count ≥ 1:** count is unchanged and both pointers advance.
- **FIFO empty and write:** no pop that edge. The serializer sees the entry on the next edge.
- **FIFO full:** `tx_ready` = 0. A pop on edge E raises `tx_ready` after E.
- **Reset mid-frame:** the frame is aborted, the FIFO is cleared, the state goes to IDLE, and `tx` = 1 after the reset edge. No partial frame resumes.

## Timing
- **Reset values:** `tx` = 1, `tx_busy` = 0. `tx_ready` = 0 while `reset` is high and 1 on the first cycle after it is released.
- **Latency:** a write at edge N into an idle, empty block is popped at edge N+1. `tx` falls after N+1.
- **Frame length:** 10 × `CLKS_PER_BIT` cycles, or 11 × `CLKS_PER_BIT` with parity.
- **`tx_busy`:** falls after the final stop-bit edge when the FIFO is empty.
- **Throughput:** one frame per frame time, sustained.
- **Output glitching:** `tx` changes only on clock edges.

## Configuration
- Macro: `UART_TX_PARITY_EN`.
- **Defined:** the PARITY state is compiled in and the frame is 8E1 or 8O1, selected by `PARITY_ODD`.
- **Undefined:** the PARITY state is absent, the frame is 8N1, and `PARITY_ODD` is ignored.

## Test plan
All directed tests use `CLK_FREQ`=1000, `BAUD`=100, so `CLKS_PER_BIT`=10, and `DEPTH`=4.
- **Reset:** hold `reset` for 3 cycles. Required: `tx` = 1, `tx_ready` = 0 during reset, `tx_ready` = 1 after release, `tx_busy` = 0.
- **Single byte:** write 0x44 at edge N. Required:
  - `tx` = 0 after N+1 for 10 cycles.
  - Then data bits 0,0,1,0,0,0,1,0, 10 cycles each.
  - Then stop bit = 1 for 10 cycles.
  - `tx_busy` = 0 after edge N+101.
- **FIFO fill:** hold `tx_valid` high with bytes 0x01..0x06 from edge N. Required:
  - Bytes 0x01..0x05 are accepted at edges N..N+4, with a pop at N+1.
  - `tx_ready` = 0 from after N+4.
  - 0x06 is accepted at the first edge after the N+101 pop.
  - Output order on `tx` is 0x01..0x06.
- **Back-to-back:** write 0x55 then 0xAA on consecutive edges. Required: the start bit of 0xAA immediately follows the last stop cycle of 0x55, with zero idle cycles between them.
- **Reset mid-frame:** write 0x44, then one more byte, then assert `reset` during data bit 3. Required: `tx` = 1 after the reset edge, `tx_busy` = 0, and no further frame is sent after release.
- **Parity (`UART_TX_PARITY_EN`, `PARITY_ODD`=0):** send 0x44, then 0x07. Required: parity bit 0 for 0x44 and 1 for 0x07, and each frame is 110 cycles long.

Source files
------------

// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: small FIFO in front of an 8N1 serializer.
// Define UART_TX_PARITY_EN to insert a parity bit (even/odd chosen by PARITY_ODD).
module uart_tx_buffered #(
   parameter int CLK_FREQ   = 100_000_000,
   parameter int BAUD       = 115200,
   parameter int DEPTH      = 4,
   parameter int PARITY_ODD = 0
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic       tx,
   output logic       tx_busy
);

   localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
   localparam int BAUD_W       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int PTR_W        = $clog2(DEPTH);
   localparam int CNT_W        = PTR_W + 1;

   localparam logic [BAUD_W-1:0] BAUD_LOAD = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [BAUD_W-1:0] BAUD_ZERO = BAUD_W'(0);
   localparam logic [BAUD_W-1:0] BAUD_ONE  = BAUD_W'(1);
   localparam logic [CNT_W-1:0]  CNT_ZERO  = CNT_W'(0);
   localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(DEPTH);
   localparam logic [PTR_W-1:0]  PTR_ZERO  = PTR_W'(0);
   localparam logic [PTR_W-1:0]  PTR_ONE   = PTR_W'(1);

   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("uart_tx_buffered: DEPTH must be a power of two, 2 or greater");
   end
   if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_parity
      $error("uart_tx_buffered: PARITY_ODD must be 0 or 1");
   end
   if (CLKS_PER_BIT < 1) begin : g_bad_baud
      $error("uart_tx_buffered: BAUD must not exceed CLK_FREQ");
   end

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
      PARITY = 3'd3,
`endif
      STOP   = 3'd4
   } state_t;

`ifdef UART_TX_PARITY_EN
   function automatic logic parity_of(input logic [7:0] b);
      parity_of = (^b) ^ PARITY_ODD[0];
   endfunction
`endif

   logic [7:0]        mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_r;
   logic [PTR_W-1:0]  rd_ptr_r;
   logic [CNT_W-1:0]  count_r;

   state_t            state_r;
   logic [BAUD_W-1:0] baud_r;
   logic [2:0]        bit_idx_r;
   logic [7:0]        shift_r;
`ifdef UART_TX_PARITY_EN
   logic              parity_r;
`endif
   logic              tx_r;
   logic              tx_busy_r;

   logic              wr_s;
   logic              pop_s;
   logic              bit_end_s;
   logic              stays_idle_s;
   logic [CNT_W-1:0]  count_next_s;
   logic [7:0]        head_s;

   assign head_s   = mem[rd_ptr_r];
   assign tx_ready = (count_r != CNT_FULL) && !reset;
   assign tx       = tx_r;
   assign tx_busy  = tx_busy_r;

   // Handshake, pop decision and next FIFO occupancy
   always_comb begin
      bit_end_s    = 1'b0;
      wr_s         = 1'b0;
      pop_s        = 1'b0;
      stays_idle_s = 1'b0;
      count_next_s = count_r;

      bit_end_s = (baud_r == BAUD_ZERO);
      wr_s      = tx_valid && tx_ready;

      case (state_r)
         IDLE:    pop_s = (count_r != CNT_ZERO);
         STOP:    pop_s = bit_end_s && (count_r != CNT_ZERO);
         default: pop_s = 1'b0;
      endcase

      case ({wr_s, pop_s})
         2'b10:   count_next_s = count_r + CNT_ONE;
         2'b01:   count_next_s = count_r - CNT_ONE;
         default: count_next_s = count_r;
      endcase

      // Serializer will sit in IDLE after this edge
      if (state_r == IDLE) begin
         stays_idle_s = !pop_s;
      end else if (state_r == STOP) begin
         stays_idle_s = bit_end_s && !pop_s;
      end else begin
         stays_idle_s = 1'b0;
      end
   end

   // FIFO storage, pointers and occupancy count
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_r <= PTR_ZERO;
         rd_ptr_r <= PTR_ZERO;
         count_r  <= CNT_ZERO;
      end else begin
         if (wr_s) begin
            mem[wr_ptr_r] <= tx_data;
            wr_ptr_r      <= wr_ptr_r + PTR_ONE;
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_ONE;
         end
         count_r <= count_next_s;
      end
   end

   // Serializer FSM with registered line and busy outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r   <= IDLE;
         baud_r    <= BAUD_ZERO;
         bit_idx_r <= 3'd0;
         shift_r   <= 8'h00;
`ifdef UART_TX_PARITY_EN
         parity_r  <= 1'b0;
`endif
         tx_r      <= 1'b1;
         tx_busy_r <= 1'b0;
      end else begin
         tx_busy_r <= !stays_idle_s || (count_next_s != CNT_ZERO);
         case (state_r)
            IDLE: begin
               tx_r <= 1'b1;
               if (pop_s) begin
                  shift_r  <= head_s;
`ifdef UART_TX_PARITY_EN
                  parity_r <= parity_of(head_s);
`endif
                  baud_r   <= BAUD_LOAD;
                  tx_r     <= 1'b0;
                  state_r  <= START;
               end
            end
            START: begin
               if (bit_end_s) begin
                  baud_r    <= BAUD_LOAD;
                  bit_idx_r <= 3'd0;
                  tx_r      <= shift_r[0];
                  state_r   <= DATA;
               end else begin
                  baud_r <= baud_r - BAUD_ONE;
               end
            end
            DATA: begin
               if (bit_end_s) begin
                  baud_r <= BAUD_LOAD;
                  if (bit_idx_r == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                     tx_r    <= parity_r;
                     state_r <= PARITY;
`else
                     tx_r    <= 1'b1;
                     state_r <= STOP;
`endif
                  end else begin
                     shift_r   <= {1'b0, shift_r[7:1]};
                     tx_r      <= shift_r[1];
                     bit_idx_r <= bit_idx_r + 3'd1;
                  end
               end else begin
                  baud_r <= baud_r - BAUD_ONE;
               end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
               if (bit_end_s) begin
                  baud_r  <= BAUD_LOAD;
                  tx_r    <= 1'b1;
                  state_r <= STOP;
               end else begin
                  baud_r <= baud_r - BAUD_ONE;
               end
            end
`endif
            STOP: begin
               if (bit_end_s) begin
                  // A waiting byte starts immediately, with no idle gap
                  if (pop_s) begin
                     shift_r  <= head_s;
`ifdef UART_TX_PARITY_EN
                     parity_r <= parity_of(head_s);
`endif
                     baud_r   <= BAUD_LOAD;
                     tx_r     <= 1'b0;
                     state_r  <= START;
                  end else begin
                     tx_r    <= 1'b1;
                     state_r <= IDLE;
                  end
               end else begin
                  baud_r <= baud_r - BAUD_ONE;
               end
            end
            default: begin
               tx_r    <= 1'b1;
               state_r <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Self-checking bench for uart_tx_buffered: directed frame table, corner sequences
// and randomized traffic checked every cycle against a frame-level queue model.
`timescale 1ns/1ps
module tb_uart_tx_buffered;

   localparam int CLK_FREQ   = 1000;
   localparam int BAUD       = 100;
   localparam int DEPTH      = 4;
   localparam int PARITY_ODD = 0;
   localparam int CPB        = CLK_FREQ / BAUD;
`ifdef UART_TX_PARITY_EN
   localparam int NBITS = 11;
`else
   localparam int NBITS = 10;
`endif
   localparam int FRAME = NBITS * CPB;

   logic       clk      = 1'b0;
   logic       reset    = 1'b1;
   logic       tx_valid = 1'b0;
   logic [7:0] tx_data  = 8'h00;
   logic       tx_ready;
   logic       tx;
   logic       tx_busy;

   uart_tx_buffered #(
      .CLK_FREQ  (CLK_FREQ),
      .BAUD      (BAUD),
      .DEPTH     (DEPTH),
      .PARITY_ODD(PARITY_ODD)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .tx_data (tx_data),
      .tx_valid(tx_valid),
      .tx_ready(tx_ready),
      .tx      (tx),
      .tx_busy (tx_busy)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int edge_no = 0;

   // Reference model: pending bytes plus the frame currently on the wire
   logic [7:0]  mq[$];
   int          rem = 0;
   logic [10:0] cur = 11'h7FF;

   // Line decoder
   logic [7:0] rxq[$];
   logic       rx_parq[$];
   bit         rx_active = 1'b0;
   int         rx_cnt = 0;
   logic [7:0] rx_byte = 8'h00;
   logic       rx_par = 1'b0;

   logic smp [0:220];
   logic bsy [0:220];

   typedef struct {
      logic [7:0] data;
      logic [9:0] line;
      logic       par;
   } vec_t;
   vec_t vecs [8];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (edge %0d)", name, act, exp, edge_no);
      end
   endtask

   function automatic logic [10:0] frame_of(input logic [7:0] b);
      logic [10:0] f;
      int ones;
      f    = 11'h7FF;
      f[0] = 1'b0;
      for (int i = 0; i < 8; i++) f[i + 1] = b[i];
      ones = $countones(b);
`ifdef UART_TX_PARITY_EN
      f[9] = (((ones + PARITY_ODD) % 2) == 1);
`endif
      if (ones < 0) f = 11'h000;
      return f;
   endfunction

   task automatic model_step();
      bit accept;
      accept = !reset && tx_valid && (mq.size() < DEPTH);
      if (reset) begin
         mq.delete();
         rem = 0;
      end else begin
         if (rem > 0) rem--;
         if (rem == 0 && mq.size() > 0) begin
            cur = frame_of(mq.pop_front());
            rem = FRAME;
         end
         if (accept) mq.push_back(tx_data);
      end
   endtask

   function automatic logic exp_tx();
      if (rem > 0) return cur[(FRAME - rem) / CPB];
      return 1'b1;
   endfunction

   function automatic logic exp_ready();
      return !reset && (mq.size() < DEPTH);
   endfunction

   function automatic logic exp_busy();
      return (rem > 0) || (mq.size() > 0);
   endfunction

   task automatic rx_decode();
      if (reset) begin
         rx_active = 1'b0;
      end else if (!rx_active) begin
         if (tx === 1'b0) begin
            rx_active = 1'b1;
            rx_cnt    = 0;
         end
      end else begin
         rx_cnt++;
         for (int k = 1; k <= 8; k++)
            if (rx_cnt == k * CPB + CPB / 2) rx_byte[k - 1] = tx;
         if (rx_cnt == 9 * CPB + CPB / 2) rx_par = tx;
         if (rx_cnt == FRAME - CPB + CPB / 2) begin
            rxq.push_back(rx_byte);
            rx_parq.push_back(rx_par);
            rx_active = 1'b0;
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      edge_no++;
      @(negedge clk);
      check("tx/ready/busy", {tx, tx_ready, tx_busy}, {exp_tx(), exp_ready(), exp_busy()});
      rx_decode();
   endtask

   task automatic drain(input int limit);
      for (int i = 0; i < limit && tx_busy !== 1'b0; i++) tick();
      check("drain busy", tx_busy, 1'b0);
      for (int i = 0; i < 3; i++) tick();
   endtask

   task automatic back_to_back(input logic [7:0] a, input logic [7:0] b,
                               input logic pa, input logic pb);
      int gaps;
      rxq.delete();
      rx_parq.delete();
      tx_valid = 1'b1;
      tx_data  = a;
      tick();
      tx_data  = b;
      tick();
      tx_valid = 1'b0;
      smp[0] = tx;
      gaps = 0;
      for (int j = 1; j <= FRAME; j++) begin
         tick();
         smp[j] = tx;
         if (tx_busy !== 1'b1) gaps++;
      end
      check("b2b first start", smp[0], 1'b0);
      check("b2b last stop", smp[FRAME - 1], 1'b1);
      check("b2b second start", smp[FRAME], 1'b0);
      check("b2b busy gaps", gaps, 0);
      drain(4 * FRAME);
      check("b2b rx count", rxq.size(), 2);
      if (rxq.size() == 2) begin
         check("b2b rx byte0", rxq[0], a);
         check("b2b rx byte1", rxq[1], b);
`ifdef UART_TX_PARITY_EN
         check("b2b parity0", rx_parq[0], pa);
         check("b2b parity1", rx_parq[1], pb);
`else
         if (pa !== pb) check("b2b parity args", rx_parq.size(), 2);
`endif
      end
   endtask

   initial begin
      int nxt;
      int acc_edge [1:6];
      int lows;
      int pct;

      vecs[0] = '{8'h44, 10'b1_0100_0100_0, 1'b0};
      vecs[1] = '{8'h07, 10'b1_0000_0111_0, 1'b1};
      vecs[2] = '{8'h55, 10'b1_0101_0101_0, 1'b0};
      vecs[3] = '{8'hAA, 10'b1_1010_1010_0, 1'b0};
      vecs[4] = '{8'h00, 10'b1_0000_0000_0, 1'b0};
      vecs[5] = '{8'hFF, 10'b1_1111_1111_0, 1'b0};
      vecs[6] = '{8'h80, 10'b1_1000_0000_0, 1'b1};
      vecs[7] = '{8'h01, 10'b1_0000_0001_0, 1'b1};

      // Reset held for three cycles
      reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("reset tx", tx, 1'b1);
         check("reset ready", tx_ready, 1'b0);
         check("reset busy", tx_busy, 1'b0);
      end
      reset = 1'b0;
      tick();
      check("post-reset ready", tx_ready, 1'b1);
      check("post-reset busy", tx_busy, 1'b0);
      check("post-reset tx", tx, 1'b1);

      // Single-byte frames from the vector table
      for (int v = 0; v < 8; v++) begin
         tx_data  = vecs[v].data;
         tx_valid = 1'b1;
         tick();
         check("tx before pop", tx, 1'b1);
         check("busy after write", tx_busy, 1'b1);
         tx_valid = 1'b0;
         for (int j = 0; j <= FRAME; j++) begin
            tick();
            smp[j] = tx;
            bsy[j] = tx_busy;
         end
         check("start first cycle", smp[0], 1'b0);
         check("start last cycle", smp[CPB - 1], 1'b0);
         for (int k = 1; k <= 8; k++)
            check("data bit", smp[k * CPB + CPB / 2], vecs[v].line[k]);
`ifdef UART_TX_PARITY_EN
         check("parity bit", smp[9 * CPB + CPB / 2], vecs[v].par);
`endif
         check("stop bit", smp[(NBITS - 1) * CPB + CPB / 2], vecs[v].line[9]);
         check("busy last stop", bsy[FRAME - 1], 1'b1);
         check("busy after frame", bsy[FRAME], 1'b0);
         check("idle after frame", smp[FRAME], 1'b1);
         tick();
      end

      // FIFO fill with tx_valid held high
      rxq.delete();
      rx_parq.delete();
      nxt = 1;
      tx_data  = 8'd1;
      tx_valid = 1'b1;
      for (int g = 0; g < 400 && nxt <= 6; g++) begin
         if (tx_ready === 1'b1) begin
            acc_edge[nxt] = edge_no + 1;
            tick();
            nxt++;
            tx_data = 8'(nxt);
            if (nxt == 6) check("ready low when full", tx_ready, 1'b0);
         end else begin
            tick();
         end
      end
      tx_valid = 1'b0;
      check("fill accepted all", nxt, 7);
      if (nxt == 7) begin
         for (int k = 2; k <= 5; k++) check("fill accept edge", acc_edge[k] - acc_edge[1], k - 1);
         check("fill sixth accept edge", acc_edge[6] - acc_edge[1], FRAME + 2);
      end
      drain(8 * FRAME);
      check("fill rx count", rxq.size(), 6);
      if (rxq.size() == 6)
         for (int k = 0; k < 6; k++) check("fill rx order", rxq[k], k + 1);

      // Back-to-back frames with no idle gap
      back_to_back(8'h55, 8'hAA, 1'b0, 1'b0);
`ifdef UART_TX_PARITY_EN
      back_to_back(8'h44, 8'h07, 1'b0, 1'b1);
`endif

      // Reset during data bit 3, with a second byte still queued
      tx_valid = 1'b1;
      tx_data  = 8'h44;
      tick();
      tx_data  = 8'h3C;
      tick();
      tx_valid = 1'b0;
      for (int j = 1; j <= 3 * CPB + CPB / 2 + CPB / 2 - 1 + 1; j++) tick();
      check("mid-frame bit3 level", tx, 1'b0);
      check("mid-frame busy", tx_busy, 1'b1);
      reset = 1'b1;
      tick();
      check("abort tx", tx, 1'b1);
      check("abort busy", tx_busy, 1'b0);
      check("abort ready", tx_ready, 1'b0);
      reset = 1'b0;
      rxq.delete();
      lows = 0;
      for (int j = 0; j < 3 * FRAME; j++) begin
         tick();
         if (tx !== 1'b1) lows++;
      end
      check("no frame after abort", lows, 0);
      check("idle after abort", tx_busy, 1'b0);
      check("no bytes after abort", rxq.size(), 0);

      // Randomized traffic in alternating light and heavy phases
      for (int blk = 0; blk < 6; blk++) begin
         pct = (blk % 2 == 1) ? 90 : 15;
         for (int c = 0; c < 500; c++) begin
            tx_valid = ($urandom_range(0, 99) < pct);
            tx_data  = 8'($urandom);
            reset    = ($urandom_range(0, 699) == 0);
            tick();
         end
      end
      reset    = 1'b0;
      tx_valid = 1'b0;
      drain((DEPTH + 2) * FRAME);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
